// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer driving a req/ack data-memory port
// Optional BUSY timeout abort is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
`ifdef MEM_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_lsop,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic        timeout_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_BYTE = 2'b01;
   localparam logic [1:0] OP_HALF = 2'b10;

   logic [1:0]  state;
   logic        lat_we;
   logic [1:0]  lat_lsop;
   logic [1:0]  lat_off;
   logic        unaligned;
   logic        accept;
   logic        finish;
   logic        timeout_hit;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   always_comb begin
      unaligned = 1'b0;
      case (req_lsop)
         OP_BYTE: unaligned = 1'b0;
         OP_HALF: unaligned = req_addr[0];
         default: unaligned = (req_addr[1:0] != 2'b00);
      endcase
   end

   assign accept   = (state == S_IDLE) && req_valid && !unaligned;
   assign misalign = (state == S_IDLE) && req_valid && unaligned;
   assign stall    = accept || (state == S_BUSY);
   // An ack arriving together with the timeout limit still completes normally.
   assign finish   = (state == S_BUSY) && (mem_ack || timeout_hit);

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      case (req_lsop)
         OP_BYTE: begin
            be_next    = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         OP_HALF: begin
            be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (lat_off)
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         2'd3:    byte_lane = mem_rdata[31:24];
         default: byte_lane = mem_rdata[7:0];
      endcase
      half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_lsop)
         OP_BYTE: load_data = {{24{byte_lane[7]}}, byte_lane};
         OP_HALF: load_data = {{16{half_lane[15]}}, half_lane};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lat_we    <= 1'b0;
         lat_lsop  <= 2'b00;
         lat_off   <= 2'b00;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state     <= S_BUSY;
                  lat_we    <= req_we;
                  lat_lsop  <= req_lsop;
                  lat_off   <= req_addr[1:0];
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  mem_be    <= be_next;
                  mem_wdata <= req_we ? wdata_next : 32'd0;
               end
            end
            S_BUSY: begin
               if (finish) begin
                  state     <= S_DONE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'd0;
                  mem_be    <= 4'd0;
                  mem_wdata <= 32'd0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= (mem_ack && !lat_we) ? load_data : 32'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt      <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= finish && !mem_ack;
         if (accept)
            to_cnt <= 8'd0;
         else if ((state == S_BUSY) && !mem_ack)
            to_cnt <= to_cnt + 8'd1;
      end
   end

   assign timeout_hit = (to_cnt == TIMEOUT_LIMIT);
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl
// Timeout scenarios are built when MEM_TIMEOUT_EN is defined (limit 4).
module tb_mem_access_ctrl;
   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_lsop;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign;
   logic        timeout_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

`ifdef MEM_TIMEOUT_EN
   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
`else
   mem_access_ctrl dut (
`endif
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_lsop(req_lsop), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misalign(misalign), .timeout_err(timeout_err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        terr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc_cnt = 0;

   logic        o_got, o_bus_seen, o_stall_rsp, o_we, o_terr;
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_wdata, o_rdata;
   int          o_rsp_cyc, o_nstall, o_req_glob, o_start_glob;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one access starting in the current cycle (cycle 0) and records what the bus and response did.
   task automatic run_access(input logic we, input logic [1:0] lsop, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rd, input int ack_cyc);
      o_got = 1'b0; o_bus_seen = 1'b0; o_nstall = 0; o_rsp_cyc = -1;
      o_req_glob = -1; o_start_glob = cyc_cnt; o_stall_rsp = 1'b1;
      req_valid = 1'b1; req_we = we; req_lsop = lsop; req_addr = addr; req_wdata = wdata;
      mem_rdata = rd;
      for (int c = 0; c < 64 && !o_got; c++) begin
         mem_ack = (ack_cyc > 0) && (c == ack_cyc);
         @(negedge clk);
         if (stall) o_nstall++;
         if (mem_req && !o_bus_seen) begin
            o_bus_seen = 1'b1; o_be = mem_be; o_addr = mem_addr;
            o_wdata = mem_wdata; o_we = mem_we; o_req_glob = cyc_cnt;
         end
         if (rsp_valid) begin
            o_got = 1'b1; o_rsp_cyc = c; o_rdata = rsp_rdata;
            o_terr = timeout_err; o_stall_rsp = stall;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_lsop = 2'b00;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({mem_req, mem_we, rsp_valid, timeout_err, stall} !== 5'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, rsp_valid, timeout_err, stall});
      end
      total++;
      if ({mem_addr, mem_be, mem_wdata, rsp_rdata} !== 100'd0) begin
         bad++; $display("FAIL reset_data: addr=%h be=%b wdata=%h rdata=%h want all 0", mem_addr, mem_be, mem_wdata, rsp_rdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp_valid, mem_req} !== 2'b00) begin
         bad++; $display("FAIL idle_ack_ignored: rsp_valid,mem_req=%b want 00", {rsp_valid, mem_req});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte;
      exp_t e;
      sb.push_back('{rdata: 32'hFFFF_FF80, terr: 1'b0});
      run_access(1'b0, 2'b01, 32'h0000_1003, 32'd0, 32'h8012_3456, 1);
      total++;
      if ({o_be, o_addr, o_we} !== {4'b1000, 32'h0000_1000, 1'b0}) begin
         bad++; $display("FAIL lb_bus: be=%b addr=%h we=%b want 1000 00001000 0", o_be, o_addr, o_we);
      end
      total++;
      if (o_rsp_cyc !== 2 || o_nstall !== 2 || o_stall_rsp !== 1'b0) begin
         bad++; $display("FAIL lb_timing: rsp_cyc=%0d stalls=%0d stall_done=%b want 2 2 0", o_rsp_cyc, o_nstall, o_stall_rsp);
      end
      total++;
      if (!o_got) begin
         bad++; $display("FAIL lb_rsp: no response want rdata=%h", sb[0].rdata); void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (o_rdata !== e.rdata || o_terr !== e.terr) begin
            bad++; $display("FAIL lb_rsp: rdata=%h terr=%b want %h %b", o_rdata, o_terr, e.rdata, e.terr);
         end
      end
   endtask

   task automatic test_store_half;
      exp_t e;
      sb.push_back('{rdata: 32'h0, terr: 1'b0});
      run_access(1'b1, 2'b10, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 4);
      total++;
      if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000}) begin
         bad++; $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h want 1 1100 beefbeef 00002000", o_we, o_be, o_wdata, o_addr);
      end
      total++;
      if (o_rsp_cyc !== 5) begin
         bad++; $display("FAIL sh_timing: rsp_cyc=%0d want 5", o_rsp_cyc);
      end
      total++;
      if (!o_got) begin
         bad++; $display("FAIL sh_rsp: no response"); void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (o_rdata !== e.rdata || o_terr !== e.terr) begin
            bad++; $display("FAIL sh_rsp: rdata=%h terr=%b want %h %b", o_rdata, o_terr, e.rdata, e.terr);
         end
      end
   endtask

   task automatic test_misalign;
      req_valid = 1'b1; req_we = 1'b0; req_lsop = 2'b11; req_addr = 32'h0000_3001;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({misalign, stall, mem_req, rsp_valid} !== 4'b1000) begin
            bad++; $display("FAIL mis_word c%0d: misalign,stall,req,rsp=%b want 1000", c, {misalign, stall, mem_req, rsp_valid});
         end
         @(posedge clk); #1;
      end
      req_lsop = 2'b10; req_addr = 32'h0000_3003;
      #1;
      total++;
      if ({misalign, stall} !== 2'b10) begin
         bad++; $display("FAIL mis_half: misalign,stall=%b want 10", {misalign, stall});
      end
      req_lsop = 2'b01;
      #1;
      total++;
      if ({misalign, stall} !== 2'b01) begin
         bad++; $display("FAIL mis_byte: misalign,stall=%b want 01", {misalign, stall});
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_lane_patterns;
      logic        we;
      logic [1:0]  op;
      logic [31:0] addr, wd, rd, x_addr, x_wd;
      logic [3:0]  x_be;
      int          ack;
      exp_t        e;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin we = 1; op = 2'b01; addr = 32'h5001; wd = 32'h1234_56A5; rd = 32'h0;         ack = 2;
                     x_be = 4'b0010; x_addr = 32'h5000; x_wd = 32'hA5A5_A5A5; sb.push_back('{32'h0, 1'b0}); end
            1: begin we = 0; op = 2'b10; addr = 32'h6000; wd = 32'h0;         rd = 32'h1234_8001; ack = 1;
                     x_be = 4'b0011; x_addr = 32'h6000; x_wd = 32'h0; sb.push_back('{32'hFFFF_8001, 1'b0}); end
            2: begin we = 0; op = 2'b00; addr = 32'h7004; wd = 32'h0;         rd = 32'hCAFE_F00D; ack = 3;
                     x_be = 4'b1111; x_addr = 32'h7004; x_wd = 32'h0; sb.push_back('{32'hCAFE_F00D, 1'b0}); end
            3: begin we = 0; op = 2'b01; addr = 32'h5001; wd = 32'h0;         rd = 32'h0000_7F00; ack = 1;
                     x_be = 4'b0010; x_addr = 32'h5000; x_wd = 32'h0; sb.push_back('{32'h0000_007F, 1'b0}); end
            default: begin we = 1; op = 2'b11; addr = 32'h7008; wd = 32'h89AB_CDEF; rd = 32'h0; ack = 1;
                     x_be = 4'b1111; x_addr = 32'h7008; x_wd = 32'h89AB_CDEF; sb.push_back('{32'h0, 1'b0}); end
         endcase
         run_access(we, op, addr, wd, rd, ack);
         total++;
         if (o_be !== x_be || o_addr !== x_addr || o_we !== we || (we && o_wdata !== x_wd)) begin
            bad++; $display("FAIL lane%0d_bus: be=%b addr=%h we=%b wdata=%h want %b %h %b %h", i, o_be, o_addr, o_we, o_wdata, x_be, x_addr, we, x_wd);
         end
         total++;
         if (!o_got) begin
            bad++; $display("FAIL lane%0d_rsp: no response", i); void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (o_rdata !== e.rdata || o_terr !== e.terr || o_rsp_cyc !== ack + 1) begin
               bad++; $display("FAIL lane%0d_rsp: rdata=%h terr=%b cyc=%0d want %h %b %0d", i, o_rdata, o_terr, o_rsp_cyc, e.rdata, e.terr, ack + 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int   first_start;
      exp_t e;
      sb.push_back('{rdata: 32'h1234_5678, terr: 1'b0});
      sb.push_back('{rdata: 32'h0000_7FFF, terr: 1'b0});
      run_access(1'b0, 2'b11, 32'h0000_4000, 32'd0, 32'h1234_5678, 1);
      first_start = o_start_glob;
      total++;
      if (!o_got) begin
         bad++; $display("FAIL b2b_first: no response"); void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (o_rdata !== e.rdata) begin
            bad++; $display("FAIL b2b_first: rdata=%h want %h", o_rdata, e.rdata);
         end
      end
      run_access(1'b0, 2'b10, 32'h0000_4002, 32'd0, 32'h7FFF_0000, 1);
      total++;
      if (o_req_glob - first_start < 4) begin
         bad++; $display("FAIL b2b_spacing: second mem_req at cycle %0d want >= 4", o_req_glob - first_start);
      end
      total++;
      if (!o_got) begin
         bad++; $display("FAIL b2b_second: no response"); void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (o_rdata !== e.rdata || o_be !== 4'b1100) begin
            bad++; $display("FAIL b2b_second: rdata=%h be=%b want %h 1100", o_rdata, o_be, e.rdata);
         end
      end
   endtask

   task automatic test_reset_mid_busy;
      logic seen;
      exp_t e;
      req_valid = 1'b1; req_we = 1'b0; req_lsop = 2'b11; req_addr = 32'h0000_8000; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1) begin
         bad++; $display("FAIL rst_busy_pre: mem_req=%b want 1", mem_req);
      end
      #1; rst_n = 1'b0; req_valid = 1'b0;
      #1;
      total++;
      if ({mem_req, mem_be, stall} !== 6'b0) begin
         bad++; $display("FAIL rst_async: mem_req=%b be=%b stall=%b want 0 0000 0", mem_req, mem_be, stall);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp_valid || mem_req) seen = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL rst_late_ack: activity=%b want 0", seen);
      end
      sb.push_back('{rdata: 32'h0BAD_CAFE, terr: 1'b0});
      run_access(1'b0, 2'b11, 32'h0000_8004, 32'd0, 32'h0BAD_CAFE, 1);
      total++;
      if (!o_got) begin
         bad++; $display("FAIL rst_recover: no response"); void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (o_rdata !== e.rdata || o_rsp_cyc !== 2) begin
            bad++; $display("FAIL rst_recover: rdata=%h cyc=%0d want %h 2", o_rdata, o_rsp_cyc, e.rdata);
         end
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      exp_t e;
      int   acks[3];
      int   cycs[3];
      acks[0] = 0; cycs[0] = 6; sb.push_back('{rdata: 32'h0, terr: 1'b1});
      acks[1] = 4; cycs[1] = 5; sb.push_back('{rdata: 32'h5555_AAAA, terr: 1'b0});
      acks[2] = 5; cycs[2] = 6; sb.push_back('{rdata: 32'h5555_AAAA, terr: 1'b0});
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 2'b00, 32'h0000_9000, 32'd0, 32'h5555_AAAA, acks[i]);
         total++;
         if (!o_got) begin
            bad++; $display("FAIL timeout%0d: no response", i); void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (o_rdata !== e.rdata || o_terr !== e.terr || o_rsp_cyc !== cycs[i]) begin
               bad++; $display("FAIL timeout%0d: rdata=%h terr=%b cyc=%0d want %h %b %0d", i, o_rdata, o_terr, o_rsp_cyc, e.rdata, e.terr, cycs[i]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_lane_patterns();
      test_back_to_back();
      test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
